// File: rtl/execute_cycle.sv
// RV32IM execute stage: operand forwarding, ALU, branch/jump resolution and the E/M register.
// Define RV32M_EN to add the single-cycle multiplier and the iterative radix-2 divider.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        JalrE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [3:0]  ALUControlE,
  input  logic [3:0]  MulDivE,
  input  logic [2:0]  BranchTypeE,
  input  logic [2:0]  LoadTypeE,
  input  logic [2:0]  StoreTypeE,
  input  logic [4:0]  RD_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        StallE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [2:0]  LoadTypeM,
  output logic [2:0]  StoreTypeM,
  output logic [31:0] ALU_ResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] srcA, srcB, writeData;
  logic [31:0] aluOut, exResult, jalrSum;
  logic        branchTaken, redirect;

  always_comb begin
    case (ForwardA_E)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALU_ResultM;
      default: srcA = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   writeData = ResultW;
      2'b10:   writeData = ALU_ResultM;
      default: writeData = RD2_E;
    endcase
  end

  assign srcB = ALUSrcE ? Imm_Ext_E : writeData;

  always_comb begin
    aluOut = '0;
    case (ALUControlE)
      4'd0:    aluOut = srcA + srcB;
      4'd1:    aluOut = srcA - srcB;
      4'd2:    aluOut = srcA & srcB;
      4'd3:    aluOut = srcA | srcB;
      4'd4:    aluOut = srcA ^ srcB;
      4'd5:    aluOut = {31'b0, $signed(srcA) < $signed(srcB)};
      4'd6:    aluOut = {31'b0, srcA < srcB};
      4'd7:    aluOut = srcA << srcB[4:0];
      4'd8:    aluOut = srcA >> srcB[4:0];
      4'd9:    aluOut = $signed(srcA) >>> srcB[4:0];
      4'd10:   aluOut = srcB;
      default: aluOut = '0;
    endcase
  end

  // Branches compare against the forwarded register value, never the immediate.
  always_comb begin
    branchTaken = 1'b0;
    case (BranchTypeE)
      3'b000:  branchTaken = (srcA == writeData);
      3'b001:  branchTaken = (srcA != writeData);
      3'b100:  branchTaken = ($signed(srcA) < $signed(writeData));
      3'b101:  branchTaken = ($signed(srcA) >= $signed(writeData));
      3'b110:  branchTaken = (srcA < writeData);
      3'b111:  branchTaken = (srcA >= writeData);
      default: branchTaken = 1'b0;
    endcase
  end

  assign redirect  = JumpE | (BranchE & branchTaken);
  assign jalrSum   = srcA + Imm_Ext_E;
  assign PCTargetE = JalrE ? {jalrSum[31:1], 1'b0} : PCE + Imm_Ext_E;

`ifdef RV32M_EN
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [2:0]  funct3;
  logic        isMul, isDiv, signedDiv;
  logic [63:0] mulA, mulB, mulProd;
  logic [31:0] mulOut;

  assign funct3    = MulDivE[2:0];
  assign isMul     = MulDivE[3] & ~funct3[2];
  assign isDiv     = MulDivE[3] & funct3[2];
  assign signedDiv = ~funct3[0];

  // Sign-extend per funct3, then the low 64 bits of an unsigned product are exact.
  assign mulA    = {{32{(funct3 != 3'b011) & srcA[31]}}, srcA};
  assign mulB    = {{32{(funct3 == 3'b001) & srcB[31]}}, srcB};
  assign mulProd = mulA * mulB;
  assign mulOut  = (funct3 == 3'b000) ? mulProd[31:0] : mulProd[63:32];

  logic [1:0]  divState;
  logic [4:0]  divCount;
  logic [31:0] divRem, divQuo, divDivisor, divDividend;
  logic        divNegQ, divNegR, divIsRem, divByZero, divOverflow;
  logic [32:0] divTrial;
  logic [31:0] quotient, remainder, divResult;

  assign divTrial = {divRem, divQuo[31]} - {1'b0, divDivisor};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divState    <= IDLE;
      divCount    <= '0;
      divRem      <= '0;
      divQuo      <= '0;
      divDivisor  <= '0;
      divDividend <= '0;
      divNegQ     <= 1'b0;
      divNegR     <= 1'b0;
      divIsRem    <= 1'b0;
      divByZero   <= 1'b0;
      divOverflow <= 1'b0;
    end else begin
      case (divState)
        IDLE: if (isDiv) begin
          divState    <= BUSY;
          divCount    <= '0;
          divRem      <= '0;
          divQuo      <= (signedDiv & srcA[31]) ? -srcA : srcA;
          divDivisor  <= (signedDiv & srcB[31]) ? -srcB : srcB;
          divDividend <= srcA;
          divNegQ     <= signedDiv & (srcA[31] ^ srcB[31]);
          divNegR     <= signedDiv & srcA[31];
          divIsRem    <= funct3[1];
          divByZero   <= (srcB == 32'h0);
          divOverflow <= signedDiv & (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
        end
        BUSY: begin
          if (!divTrial[32]) begin
            divRem <= divTrial[31:0];
            divQuo <= {divQuo[30:0], 1'b1};
          end else begin
            divRem <= {divRem[30:0], divQuo[31]};
            divQuo <= {divQuo[30:0], 1'b0};
          end
          divCount <= divCount + 5'd1;
          if (divCount == 5'd31) divState <= DONE;
        end
        default: divState <= IDLE;
      endcase
    end
  end

  always_comb begin
    quotient  = divNegQ ? -divQuo : divQuo;
    remainder = divNegR ? -divRem : divRem;
    if (divByZero) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = divDividend;
    end else if (divOverflow) begin
      quotient  = 32'h8000_0000;
      remainder = 32'h0;
    end
    divResult = divIsRem ? remainder : quotient;
  end

  // StallE is gated by reset so an abort drops the stall immediately.
  assign StallE   = rst & (((divState == IDLE) & isDiv) | (divState == BUSY));
  assign PCSrcE   = redirect & ~isDiv;
  assign exResult = isMul ? mulOut : (divState == DONE) ? divResult : aluOut;
`else
  logic unusedMulDiv;
  assign unusedMulDiv = ^MulDivE;
  assign StallE       = 1'b0;
  assign PCSrcE       = redirect;
  assign exResult     = aluOut;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || StallE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      LoadTypeM   <= '0;
      StoreTypeM  <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      LoadTypeM   <= LoadTypeE;
      StoreTypeM  <= StoreTypeE;
      ALU_ResultM <= exResult;
      WriteDataM  <= writeData;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; M-extension scenarios run when RV32M_EN is defined.
module tb_execute_cycle;
  logic        clk, rst;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE, MulDivE;
  logic [2:0]  BranchTypeE, LoadTypeE, StoreTypeE;
  logic [4:0]  RD_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [2:0]  LoadTypeM, StoreTypeM;

  int checks = 0;
  int failures = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .MulDivE(MulDivE), .BranchTypeE(BranchTypeE), .LoadTypeE(LoadTypeE), .StoreTypeE(StoreTypeE),
    .RD_E(RD_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .LoadTypeM(LoadTypeM),
    .StoreTypeM(StoreTypeM), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearIn();
    RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; JalrE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ALUControlE = 0; MulDivE = 0; BranchTypeE = 0; LoadTypeE = 0;
    StoreTypeE = 0; RD_E = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
    PCPlus4E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearIn();
    RD1_E = 32'h11; RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h44;
    rst = 0;
    #3;
    checks++; if (ALU_ResultM !== 32'h0) begin failures++; $display("FAIL reset_alu got %h expected 0", ALU_ResultM); end
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL reset_regwrite got %b expected 0", RegWriteM); end
    checks++; if (RD_M !== 5'd0 || PCPlus4M !== 32'h0) begin failures++; $display("FAIL reset_fields got rd=%h pc4=%h expected 0", RD_M, PCPlus4M); end
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL reset_stall got %b expected 0", StallE); end
    step(); step();
    rst = 1;
    clearIn();
    step();
  endtask

  task automatic test_forward();
    clearIn();
    RD1_E = 32'd2; Imm_Ext_E = 32'd3; ALUSrcE = 1;
    step();
    checks++; if (ALU_ResultM !== 32'd5) begin failures++; $display("FAIL fwd_seed got %h expected 5", ALU_ResultM); end
    ForwardA_E = 2'b10; RD1_E = 32'd100; Imm_Ext_E = 32'd7; RegWriteE = 1; RD_E = 5'd9;
    step();
    checks++; if (ALU_ResultM !== 32'd12) begin failures++; $display("FAIL fwd_m_add got %h expected c", ALU_ResultM); end
    checks++; if (RegWriteM !== 1'b1 || RD_M !== 5'd9) begin failures++; $display("FAIL fwd_ctrl got rw=%b rd=%h expected 1/9", RegWriteM, RD_M); end
    clearIn();
    ForwardB_E = 2'b01; ResultW = 32'hDEAD; RD2_E = 32'h1; ALUControlE = 4'd10; MemWriteE = 1;
    step();
    checks++; if (ALU_ResultM !== 32'hDEAD) begin failures++; $display("FAIL fwd_w_passb got %h expected dead", ALU_ResultM); end
    checks++; if (WriteDataM !== 32'hDEAD || MemWriteM !== 1'b1) begin failures++; $display("FAIL fwd_w_wdata got %h mw=%b expected dead/1", WriteDataM, MemWriteM); end
    clearIn();
    ForwardA_E = 2'b11; RD1_E = 32'd4; ResultW = 32'h999; Imm_Ext_E = 32'd1; ALUSrcE = 1;
    step();
    checks++; if (ALU_ResultM !== 32'd5) begin failures++; $display("FAIL fwd_11_regfile got %h expected 5", ALU_ResultM); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op [11];
    logic [31:0] a [11];
    logic [31:0] b [11];
    logic [31:0] exp [11];
    op  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
    a   = '{32'd10, 32'hF0F0, 32'h00F0, 32'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
            32'h80000000, 32'h80000000, 32'h5, 32'h5};
    b   = '{32'd3, 32'hFF00, 32'h0F00, 32'h0F, 32'h1, 32'h1, 32'd33, 32'd4, 32'd4, 32'hABCD, 32'h6};
    exp = '{32'd7, 32'hF000, 32'h0FF0, 32'hF0, 32'h1, 32'h0, 32'h2,
            32'h08000000, 32'hF8000000, 32'hABCD, 32'h0};
    for (int i = 0; i < 11; i++) begin
      clearIn();
      ALUControlE = op[i]; RD1_E = a[i]; RD2_E = b[i];
      step();
      checks++;
      if (ALU_ResultM !== exp[i]) begin
        failures++; $display("FAIL alu_op%0d got %h expected %h", op[i], ALU_ResultM, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    clearIn();
    BranchE = 1; BranchTypeE = 3'b100; RD1_E = 32'hFFFFFFFF; RD2_E = 32'h1;
    PCE = 32'h100; Imm_Ext_E = 32'h20; ALUSrcE = 1;
    #1;
    checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL blt_taken got %b expected 1", PCSrcE); end
    checks++; if (PCTargetE !== 32'h120) begin failures++; $display("FAIL blt_target got %h expected 120", PCTargetE); end
    BranchTypeE = 3'b110; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL bltu_nottaken got %b expected 0", PCSrcE); end
    BranchTypeE = 3'b101; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL bge_nottaken got %b expected 0", PCSrcE); end
    BranchTypeE = 3'b111; #1;
    checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL bgeu_taken got %b expected 1", PCSrcE); end
    BranchTypeE = 3'b000; RD1_E = 32'h5; RD2_E = 32'h5; #1;
    checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL beq_taken got %b expected 1", PCSrcE); end
    BranchTypeE = 3'b001; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL bne_nottaken got %b expected 0", PCSrcE); end
    clearIn();
    JumpE = 1; JalrE = 1; RD1_E = 32'h1001; Imm_Ext_E = 32'h10; PCE = 32'h400; #1;
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1010) begin failures++; $display("FAIL jalr got src=%b tgt=%h expected 1/1010", PCSrcE, PCTargetE); end
    step();
  endtask

  task automatic test_passthrough();
    clearIn();
    ResultSrcE = 2'd2; LoadTypeE = 3'b101; StoreTypeE = 3'b010; PCPlus4E = 32'h204;
    MemWriteE = 1; RD_E = 5'd17; RD1_E = 32'h77;
    step();
    checks++; if (ResultSrcM !== 2'd2) begin failures++; $display("FAIL pass_resultsrc got %h expected 2", ResultSrcM); end
    checks++; if (LoadTypeM !== 3'b101 || StoreTypeM !== 3'b010) begin failures++; $display("FAIL pass_types got %b/%b expected 101/010", LoadTypeM, StoreTypeM); end
    checks++; if (PCPlus4M !== 32'h204 || RD_M !== 5'd17) begin failures++; $display("FAIL pass_pc4_rd got %h/%h expected 204/11", PCPlus4M, RD_M); end
  endtask

  task automatic test_async_reset();
    #2 rst = 0;
    #1;
    checks++; if (ALU_ResultM !== 32'h0 || PCPlus4M !== 32'h0 || MemWriteM !== 1'b0 || LoadTypeM !== 3'b0)
      begin failures++; $display("FAIL async_reset got alu=%h pc4=%h mw=%b lt=%b expected 0", ALU_ResultM, PCPlus4M, MemWriteM, LoadTypeM); end
    clearIn();
    step();
    rst = 1;
    step();
  endtask

`ifdef RV32M_EN
  task automatic test_mul();
    logic [2:0]  f3 [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] exp [4];
    f3  = '{3'b001, 3'b011, 3'b000, 3'b010};
    a   = '{32'h80000000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
    b   = '{32'h80000000, 32'd2, 32'hFFFFFFFE, 32'd2};
    exp = '{32'h40000000, 32'h1, 32'hFFFFFFFA, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      clearIn();
      MulDivE = {1'b1, f3[i]}; RD1_E = a[i]; RD2_E = b[i];
      #1;
      checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL mul_nostall f3=%0d got %b expected 0", f3[i], StallE); end
      step();
      checks++;
      if (ALU_ResultM !== exp[i]) begin
        failures++; $display("FAIL mul_f3_%0d got %h expected %h", f3[i], ALU_ResultM, exp[i]);
      end
    end
    clearIn();
  endtask

  task automatic runDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int  stalls;
    logic bubbleBad;
    MulDivE = {1'b1, f3}; RD1_E = a; RD2_E = b; ALUSrcE = 0; ForwardA_E = 0; ForwardB_E = 0;
    ALUControlE = 4'd0; RegWriteE = 1; RD_E = 5'd7; BranchE = 0; JumpE = 0;
    #1;
    stalls = 0; bubbleBad = 0;
    while (StallE === 1'b1 && stalls < 40) begin
      stalls++;
      step();
      if (RegWriteM !== 1'b0) bubbleBad = 1;
    end
    checks++; if (stalls != 33) begin failures++; $display("FAIL %s_stall_cycles got %0d expected 33", name, stalls); end
    checks++; if (bubbleBad) begin failures++; $display("FAIL %s_bubble got RegWriteM=1 during stall expected 0", name); end
    step();
    checks++; if (ALU_ResultM !== exp) begin failures++; $display("FAIL %s_result got %h expected %h", name, ALU_ResultM, exp); end
    checks++; if (RegWriteM !== 1'b1 || RD_M !== 5'd7) begin failures++; $display("FAIL %s_ctrl got rw=%b rd=%h expected 1/7", name, RegWriteM, RD_M); end
  endtask

  task automatic test_div();
    clearIn();
    runDiv(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2"); clearIn(); step();
    runDiv(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2"); clearIn(); step();
    runDiv(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0"); clearIn(); step();
    runDiv(3'b111, 32'd5, 32'd0, 32'd5, "remu_by0"); clearIn(); step();
    runDiv(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf"); clearIn(); step();
    runDiv(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"); clearIn(); step();
  endtask

  task automatic test_back_to_back();
    clearIn();
    runDiv(3'b101, 32'd100, 32'd7, 32'd14, "b2b_first");
    runDiv(3'b111, 32'd100, 32'd9, 32'd1, "b2b_second");
    clearIn();
    #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL b2b_release got %b expected 0", StallE); end
    step();
  endtask

  task automatic test_div_reset();
    clearIn();
    MulDivE = 4'b1100; RD1_E = 32'hFFFFFFF9; RD2_E = 32'd2; RegWriteE = 1; RD_E = 5'd7;
    for (int i = 0; i < 11; i++) step();
    checks++; if (StallE !== 1'b1) begin failures++; $display("FAIL divrst_busy got %b expected 1", StallE); end
    #2 rst = 0;
    #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL divrst_stall got %b expected 0", StallE); end
    checks++; if (ALU_ResultM !== 32'h0 || RegWriteM !== 1'b0 || RD_M !== 5'd0) begin failures++; $display("FAIL divrst_m got alu=%h rw=%b rd=%h expected 0", ALU_ResultM, RegWriteM, RD_M); end
    clearIn();
    step();
    rst = 1;
    step();
    RD1_E = 32'd1; Imm_Ext_E = 32'd2; ALUSrcE = 1; RegWriteE = 1; RD_E = 5'd4;
    #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL divrst_add_stall got %b expected 0", StallE); end
    step();
    checks++; if (ALU_ResultM !== 32'd3 || RD_M !== 5'd4) begin failures++; $display("FAIL divrst_add got %h rd=%h expected 3/4", ALU_ResultM, RD_M); end
    clearIn();
  endtask
`else
  task automatic test_muldiv_ignored();
    clearIn();
    MulDivE = 4'b1100; RD1_E = 32'd3; RD2_E = 32'd4; ALUControlE = 4'd0;
    #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL nom_stall got %b expected 0", StallE); end
    step();
    checks++; if (ALU_ResultM !== 32'd7) begin failures++; $display("FAIL nom_div_alu got %h expected 7", ALU_ResultM); end
    MulDivE = 4'b1001;
    step();
    checks++; if (ALU_ResultM !== 32'd7) begin failures++; $display("FAIL nom_mul_alu got %h expected 7", ALU_ResultM); end
    clearIn();
  endtask
`endif

  initial begin
    rst = 1;
    test_reset();
    test_forward();
    test_alu_ops();
    test_branch();
    test_passthrough();
    test_async_reset();
`ifdef RV32M_EN
    test_mul();
    test_div();
    test_back_to_back();
    test_div_reset();
`else
    test_muldiv_ignored();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the RV32IM 5-stage pipeline, between the decode/execute register and the memory stage. It selects forwarded operands, runs the base-ISA ALU, and resolves branches and jumps. It also executes M-extension ops: a single-cycle multiply and an iterative radix-2 divider that stalls the front of the pipe. It owns the E/M pipeline register that feeds the memory stage.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE  in  1 each  decode controls
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 pass SrcB; others → 0
- MulDivE  in  4  [3] valid, [2:0] = RV funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- BranchTypeE  in  3  RV branch funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- LoadTypeE, StoreTypeE  in  3 each  passed through
- RD_E  in  5  destination register
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each
- ForwardA_E, ForwardB_E  in  2 each  00 register file, 01 ResultW, 10 ALU_ResultM; 11 → register file
- ResultW  in  32  writeback result
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  32  redirect target
- StallE  out  1  hold F, D and E registers
- RegWriteM, MemWriteM  out  1 each
- ResultSrcM  out  2
- RD_M  out  5
- LoadTypeM, StoreTypeM  out  3 each
- ALU_ResultM, WriteDataM, PCPlus4M  out  32 each

## Operation
- Operand forwarding:
  - SrcA = forward mux A.
  - WriteData = forward mux B.
  - SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
- Shifts use SrcB[4:0]. SLT and SLTU produce 32'h0/32'h1.
- Branch resolution:
  - PCSrcE = JumpE | (BranchE & cond(BranchTypeE, SrcA, WriteData)).
  - PCTargetE = JalrE ? (SrcA+Imm_Ext_E) & ~1 : PCE+Imm_Ext_E.
- Multiply (MulDivE[3] with funct3 [2]=0): 64-bit product formed combinationally.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word with the signedness of funct3.
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE with a divide valid: StallE=1, latch |SrcA|, |SrcB|, the result signs and the op; counter=0; go to BUSY.
  - BUSY: one restoring-divide step per cycle, StallE=1; after step 31, go to DONE.
  - DONE: StallE=0; the result drives the ALU result path; return to IDLE.
- Divide special cases are resolved in DONE:
  - Divisor 0 → quotient 32'hFFFFFFFF, remainder = dividend.
  - DIV/REM of 32'h80000000 by 32'hFFFFFFFF → quotient 32'h80000000, remainder 0.
- Operands are latched at the IDLE cycle. Later changes to forwarded values (M and W drain during the stall) are ignored.
- E/M register:
  - A bubble (RegWriteM=0, MemWriteM=0, all other fields 0) is loaded on every cycle with StallE=1.
  - Otherwise the register loads the E values. ALU_ResultM gets the ALU, multiply or divide result; WriteDataM gets the forwarded B.

## Timing
- Reset values: all M outputs 0, FSM IDLE, counter 0, StallE 0. The reset is asynchronous and takes effect immediately.
- Reset mid-divide aborts: FSM to IDLE, no result is written.
- ALU ops and multiply: 1 cycle in E; the result appears on ALU_ResultM after the next edge.
- Divide: 34 cycles in E (1 IDLE + 32 BUSY + 1 DONE). StallE is high for the first 33 of them. The result is on ALU_ResultM after the DONE edge.
- PCSrcE and PCTargetE are combinational in the same cycle. A divide never asserts PCSrcE.
- A divide immediately followed by another divide: the second enters IDLE on the cycle after DONE, with no idle gap.

## Configuration
- RV32M_EN defined: multiply and divide are implemented as above.
- RV32M_EN undefined: MulDivE is ignored, there is no FSM, StallE is tied to 0, and the ALUControlE result is always used.

## Test plan
- ADD with ForwardA_E=10, ALU_ResultM=5, Imm=7, ALUSrcE=1 → ALU_ResultM=12 next cycle, RegWriteM follows RegWriteE.
- BLT, SrcA=-1, B=1, PCE=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120. Same with BLTU → PCSrcE=0.
- MULH 0x80000000 × 0x80000000 → ALU_ResultM=0x40000000. MULHU 0xFFFFFFFF × 2 → 0x1.
- DIV -7/2 → StallE high 33 cycles and bubbles into M, then ALU_ResultM=0xFFFFFFFD. REM of the same → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF. REM 0x80000000 / -1 → 0. Both after 34 cycles.
- Reset pulse at BUSY step 10 → StallE=0 and all M outputs 0 immediately. A following ADD completes normally.
